// File: rtl/serial_pkg.sv
// serial_pkg: shared constants for the serial frame transmitter.
// State encoding and the default word width used by the detector bench.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial shifter with a one-word holding buffer.
// Streams WIDTH-bit words one bit per clock with a frame marker per word.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_valid, hold_valid_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             ser_out_n, ser_valid_n, frame_start_n;
    logic             transfer;

    // Bit that goes on the line first for a word held in the shifter.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Drop the bit just sent so the next one moves to the head position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign din_ready = !hold_valid;
    assign transfer  = din_valid && din_ready;
    assign busy      = (state == S_SHIFT) || hold_valid;

    // Next-state logic: load, shift, refill from buffer or din, or go idle.
    always_comb begin
        state_n       = state;
        shreg_n       = shreg;
        hold_n        = hold;
        hold_valid_n  = hold_valid;
        cnt_n         = cnt;
        frame_start_n = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (transfer) begin
                    shreg_n       = din;
                    cnt_n         = LAST_IDX;
                    state_n       = S_SHIFT;
                    frame_start_n = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt == '0) begin
                    if (hold_valid) begin
                        shreg_n       = hold;
                        hold_valid_n  = 1'b0;
                        cnt_n         = LAST_IDX;
                        frame_start_n = 1'b1;
                    end else if (transfer) begin
                        shreg_n       = din;
                        cnt_n         = LAST_IDX;
                        frame_start_n = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    shreg_n = advance(shreg);
                    cnt_n   = cnt - 1'b1;
                    if (transfer) begin
                        hold_n       = din;
                        hold_valid_n = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        ser_valid_n = (state_n == S_SHIFT);
        ser_out_n   = ser_valid_n ? head(shreg_n) : IDLE_BIT;
    end

    // State and registered outputs; reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            hold        <= '0;
            hold_valid  <= 1'b0;
            cnt         <= '0;
            ser_out     <= IDLE_BIT;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            hold        <= hold_n;
            hold_valid  <= hold_valid_n;
            cnt         <= cnt_n;
            ser_out     <= ser_out_n;
            ser_valid   <= ser_valid_n;
            frame_start <= frame_start_n;
        end
    end

endmodule
